// File: rtl/snoop_pkg.sv
// Shared snoop-protocol definitions: message layout, op codes, line states.
package snoop_pkg;

   localparam int unsigned ID_W       = 2;
   localparam int unsigned OP_W       = 2;
   localparam int unsigned MSG_ADDR_W = 3;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned IDX_W      = 2;
   localparam int unsigned MSG_W      = ID_W + OP_W + MSG_ADDR_W + DATA_W;

   typedef enum logic [OP_W-1:0] {
      OP_NONE       = 2'b00,
      OP_READ_MISS  = 2'b01,
      OP_WRITE_MISS = 2'b10,
      OP_INVALIDATE = 2'b11
   } op_e;

   // Code 11 is unused and behaves as invalid.
   typedef enum logic [1:0] {
      ST_I = 2'b00,
      ST_S = 2'b01,
      ST_M = 2'b10,
      ST_X = 2'b11
   } lstate_e;

   typedef enum logic [1:0] {
      FSM_IDLE    = 2'b00,
      FSM_LOOKUP  = 2'b01,
      FSM_RESPOND = 2'b10,
      FSM_UPDATE  = 2'b11
   } fsm_e;

   // Bus message: [14:13] source, [12:11] op, [10:8] address, [7:0] data.
   typedef struct packed {
      logic [ID_W-1:0]       src;
      op_e                   op;
      logic [MSG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } msg_t;

   typedef struct packed {
      lstate_e           state;
      logic              tag;
      logic [DATA_W-1:0] data;
   } line_t;

   function automatic logic line_valid(input lstate_e s);
      return (s == ST_S) || (s == ST_M);
   endfunction

endpackage

// File: rtl/snoop_responder_if.sv
// Broadcast-bus side of the snoop responder.
interface snoop_responder_if;
   import snoop_pkg::*;

   logic [MSG_W-1:0]      bus_IN;
   logic [MSG_W-1:0]      bus_R_OUT;
   logic                  resp_valid;
   logic                  resp_ready;
   logic                  write_back;
   logic [MSG_ADDR_W-1:0] wb_tag;
   logic [DATA_W-1:0]     wb_data;
   logic                  snoop_busy;

   modport master (
      output bus_IN, resp_ready,
      input  bus_R_OUT, resp_valid, write_back, wb_tag, wb_data, snoop_busy
   );

   modport slave (
      input  bus_IN, resp_ready,
      output bus_R_OUT, resp_valid, write_back, wb_tag, wb_data, snoop_busy
   );
endinterface

// File: rtl/snoop_state_table.sv
// Snoop line array: full-line processor write port plus state-only snoop write port.
module snoop_state_table
   import snoop_pkg::*;
#(
   parameter int unsigned NLINES = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             cpu_we,
   input  logic [IDX_W-1:0] cpu_idx,
   input  line_t            cpu_line,
   input  logic             snp_we,
   input  logic [IDX_W-1:0] snp_idx,
   input  lstate_e          snp_state,
   input  logic [IDX_W-1:0] rd_idx,
   output line_t            rd_line_c
);

   line_t lines [NLINES];

   // Both ports may write in one cycle; the caller keeps them on different indices.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NLINES); i++) lines[i] <= '0;
      end else begin
         if (cpu_we) lines[cpu_idx] <= cpu_line;
         if (snp_we) lines[snp_idx].state <= snp_state;
      end
   end

   // Lookup sees only contents registered before the current edge.
   assign rd_line_c = lines[rd_idx];

endmodule

// File: rtl/snoop_responder.sv
// Snoop responder: looks up bus messages, supplies M data, downgrades/invalidates lines.
module snoop_responder
   import snoop_pkg::*;
#(
   parameter int unsigned NLINES = 4,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ID_W-1:0]   ID,
   input  logic              cpu_wr,
   input  logic [IDX_W-1:0]  cpu_idx,
   input  logic [1:0]        cpu_state,
   input  logic              cpu_tag,
   input  logic [DATA_W-1:0] cpu_data,
   output logic              cpu_retry,
   snoop_responder_if.slave  bus
);

   fsm_e                  fsm;
   op_e                   cur_op;
   logic [ADDR_W-1:0]     cur_addr;
   logic                  pend_vld;
   op_e                   pend_op;
   logic [ADDR_W-1:0]     pend_addr;

   msg_t                  in_msg;
   logic                  snooped;
   logic                  holding;
   logic [IDX_W-1:0]      cur_idx;
   line_t                 rd_line;
   logic                  hit;
   logic                  cpu_we;
   line_t                 cpu_line;
   lstate_e               snp_state;
   logic                  unused_in_data;

   assign in_msg         = msg_t'(bus.bus_IN);
   assign unused_in_data = ^in_msg.data;
   assign snooped        = (in_msg.op != OP_NONE) && (in_msg.src != ID);
   assign holding        = (fsm != FSM_IDLE);
   assign cur_idx        = cur_addr[IDX_W-1:0];
   assign hit            = line_valid(rd_line.state) && (rd_line.tag == cur_addr[ADDR_W-1]);

   // Snoop side wins any collision on the index it is holding.
   assign cpu_retry = cpu_wr && holding && (cpu_idx == cur_idx);
   assign cpu_we    = cpu_wr && !cpu_retry;
   assign cpu_line  = '{state: lstate_e'(cpu_state), tag: cpu_tag, data: cpu_data};
   assign snp_state = (cur_op == OP_READ_MISS) ? ST_S : ST_I;

   // Write-back strobe is exactly the response handshake cycle.
   assign bus.write_back = bus.resp_valid & bus.resp_ready;
   assign bus.snoop_busy = pend_vld;

   snoop_state_table #(.NLINES(NLINES)) u_table (
      .clock     (clock),
      .reset_n   (reset_n),
      .cpu_we    (cpu_we),
      .cpu_idx   (cpu_idx),
      .cpu_line  (cpu_line),
      .snp_we    (fsm == FSM_UPDATE),
      .snp_idx   (cur_idx),
      .snp_state (snp_state),
      .rd_idx    (cur_idx),
      .rd_line_c (rd_line)
   );

   // Snoop FSM, pending buffer and registered response outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fsm            <= FSM_IDLE;
         cur_op         <= OP_NONE;
         cur_addr       <= '0;
         pend_vld       <= 1'b0;
         pend_op        <= OP_NONE;
         pend_addr      <= '0;
         bus.resp_valid <= 1'b0;
         bus.bus_R_OUT  <= '0;
         bus.wb_tag     <= '0;
         bus.wb_data    <= '0;
      end else begin
         case (fsm)
            FSM_IDLE: begin
               if (pend_vld) begin
                  cur_op   <= pend_op;
                  cur_addr <= pend_addr;
                  pend_vld <= 1'b0;
                  fsm      <= FSM_LOOKUP;
               end else if (snooped) begin
                  cur_op   <= in_msg.op;
                  cur_addr <= ADDR_W'(in_msg.addr);
                  fsm      <= FSM_LOOKUP;
               end
            end
            FSM_LOOKUP: begin
               if (hit && rd_line.state == ST_M &&
                   (cur_op == OP_READ_MISS || cur_op == OP_WRITE_MISS)) begin
                  bus.resp_valid <= 1'b1;
                  bus.bus_R_OUT  <= MSG_W'({ID, OP_READ_MISS, cur_addr, rd_line.data});
                  bus.wb_tag     <= MSG_ADDR_W'(cur_addr);
                  bus.wb_data    <= rd_line.data;
                  fsm            <= FSM_RESPOND;
               end else if (hit && rd_line.state == ST_S &&
                            (cur_op == OP_WRITE_MISS || cur_op == OP_INVALIDATE)) begin
                  fsm <= FSM_UPDATE;
               end else begin
                  fsm <= FSM_IDLE;
               end
            end
            FSM_RESPOND: begin
               if (bus.resp_ready) begin
                  bus.resp_valid <= 1'b0;
                  bus.bus_R_OUT  <= '0;
                  fsm            <= FSM_UPDATE;
               end
            end
            FSM_UPDATE: fsm <= FSM_IDLE;
            default:    fsm <= FSM_IDLE;
         endcase

         // Messages arriving while busy are parked once; extras are dropped.
         if (holding && snooped && !pend_vld) begin
            pend_vld  <= 1'b1;
            pend_op   <= in_msg.op;
            pend_addr <= ADDR_W'(in_msg.addr);
         end
      end
   end

endmodule
